// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit.
//   state_e  : sequencer state encoding (RUN / MEM_WAIT / TRAP)
//   RegIdxW  : architectural register index width
package hazard_control_unit_pkg;

  localparam int unsigned RegIdxW = 5;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StTrap    = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle of pipeline hazard inputs and pipeline control outputs.
//   slave  : view used by the hazard control unit (hazard info in, controls out)
//   master : view used by the pipeline (drives hazard info, consumes controls)
interface hazard_control_unit_if #(
  parameter int unsigned CNT_W = 16
);
  import hazard_control_unit_pkg::*;

  // Hazard information from the pipeline
  logic               ID_EX_MemRead;
  logic [RegIdxW-1:0] ID_EX_RegisterRD;
  logic [RegIdxW-1:0] IF_ID_RegisterRS1;
  logic [RegIdxW-1:0] IF_ID_RegisterRS2;
  logic               IF_ID_UsesRS1;
  logic               IF_ID_UsesRS2;
  logic               BranchTaken;
  logic               EX_MEM_MemAccess;
  logic               DMemReady;

  // Pipeline controls and status
  logic               PCWrite;
  logic               IF_ID_Write;
  logic               ID_EX_Write;
  logic               EX_MEM_Write;
  logic               ID_EX_Bubble;
  logic               IF_ID_Flush;
  logic               ID_EX_Flush;
  logic               MEM_WB_Bubble;
  logic               MemTimeoutErr;
  logic [CNT_W-1:0]   StallCount;
  logic [CNT_W-1:0]   FlushCount;

  modport slave (
    input  ID_EX_MemRead, ID_EX_RegisterRD, IF_ID_RegisterRS1, IF_ID_RegisterRS2,
           IF_ID_UsesRS1, IF_ID_UsesRS2, BranchTaken, EX_MEM_MemAccess, DMemReady,
    output PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, ID_EX_Bubble, IF_ID_Flush,
           ID_EX_Flush, MEM_WB_Bubble, MemTimeoutErr, StallCount, FlushCount
  );

  modport master (
    output ID_EX_MemRead, ID_EX_RegisterRD, IF_ID_RegisterRS1, IF_ID_RegisterRS2,
           IF_ID_UsesRS1, IF_ID_UsesRS2, BranchTaken, EX_MEM_MemAccess, DMemReady,
    input  PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, ID_EX_Bubble, IF_ID_Flush,
           ID_EX_Flush, MEM_WB_Bubble, MemTimeoutErr, StallCount, FlushCount
  );

endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter used for the performance counters.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset, clears the count
//   inc_i   : add one this cycle (ignored once all-ones)
//   count_o : current count
module hazard_control_unit_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, taken-branch flushes,
// data-memory wait freezes and a hung-memory trap, plus stall/flush counters.
//   clk   : core clock, rising edge
//   reset : asynchronous active-high reset
//   hcu   : hazard inputs and pipeline enables/bubbles/flushes/status (slave view)
// Control outputs are combinational from the registered state and current inputs.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input logic                  clk,
  input logic                  reset,
  hazard_control_unit_if.slave hcu
);

  localparam int unsigned         WaitW     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0]    WaitLimit = WaitW'(MEM_TIMEOUT);
  localparam logic [WaitW-1:0]    WaitOne   = WaitW'(1);
  // A one-cycle timeout traps straight from the first stalled access.
  localparam state_e              FirstWait = (MEM_TIMEOUT <= 1) ? StTrap : StMemWait;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;

  logic memwait, loaduse, run_eval, freeze, flush_inc, stall_inc;
  logic pc_we, ifid_we, idex_we, exmem_we;
  logic idex_bub, ifid_fl, idex_fl, memwb_bub;

  assign memwait = hcu.EX_MEM_MemAccess & ~hcu.DMemReady;
  assign loaduse = hcu.ID_EX_MemRead && (hcu.ID_EX_RegisterRD != '0) &&
                   (((hcu.ID_EX_RegisterRD == hcu.IF_ID_RegisterRS1) && hcu.IF_ID_UsesRS1) ||
                    ((hcu.ID_EX_RegisterRD == hcu.IF_ID_RegisterRS2) && hcu.IF_ID_UsesRS2));

  always_comb begin
    pc_we     = 1'b1;
    ifid_we   = 1'b1;
    idex_we   = 1'b1;
    exmem_we  = 1'b1;
    idex_bub  = 1'b0;
    ifid_fl   = 1'b0;
    idex_fl   = 1'b0;
    memwb_bub = 1'b0;
    state_d   = state_q;
    wait_d    = wait_q;
    run_eval  = 1'b0;
    freeze    = 1'b0;
    flush_inc = 1'b0;

    unique case (state_q)
      StRun: run_eval = 1'b1;
      StMemWait: begin
        if (hcu.DMemReady) begin
          // Access completes: act on whatever hazard was held during the wait.
          run_eval = 1'b1;
          state_d  = StRun;
          wait_d   = '0;
        end else begin
          freeze = 1'b1;
          wait_d = wait_q + WaitOne;
          if (wait_d >= WaitLimit) begin
            state_d = StTrap;
          end
        end
      end
      StTrap:  freeze = 1'b1;
      default: state_d = StRun;
    endcase

    if (run_eval) begin
      if (memwait) begin
        freeze  = 1'b1;
        state_d = FirstWait;
        wait_d  = WaitOne;
      end else if (hcu.BranchTaken) begin
        // Branch wins over load-use: the stalled instruction is squashed anyway.
        ifid_fl   = 1'b1;
        idex_fl   = 1'b1;
        flush_inc = 1'b1;
      end else if (loaduse) begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_bub = 1'b1;
      end
    end

    if (freeze) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      idex_we   = 1'b0;
      exmem_we  = 1'b0;
      memwb_bub = 1'b1;
    end

    if (reset) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      idex_we   = 1'b0;
      exmem_we  = 1'b0;
      idex_bub  = 1'b0;
      ifid_fl   = 1'b0;
      idex_fl   = 1'b0;
      memwb_bub = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign stall_inc = ~pc_we & ~reset;

  logic [CNT_W-1:0] stall_count, flush_count;

  hazard_control_unit_sat_counter #(
    .Width(CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk),
    .rst_i  (reset),
    .inc_i  (stall_inc),
    .count_o(stall_count)
  );

  hazard_control_unit_sat_counter #(
    .Width(CNT_W)
  ) u_flush_cnt (
    .clk_i  (clk),
    .rst_i  (reset),
    .inc_i  (flush_inc),
    .count_o(flush_count)
  );

  assign hcu.PCWrite       = pc_we;
  assign hcu.IF_ID_Write   = ifid_we;
  assign hcu.ID_EX_Write   = idex_we;
  assign hcu.EX_MEM_Write  = exmem_we;
  assign hcu.ID_EX_Bubble  = idex_bub;
  assign hcu.IF_ID_Flush   = ifid_fl;
  assign hcu.ID_EX_Flush   = idex_fl;
  assign hcu.MEM_WB_Bubble = memwb_bub;
  assign hcu.MemTimeoutErr = (state_q == StTrap);
  assign hcu.StallCount    = stall_count;
  assign hcu.FlushCount    = flush_count;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit (MEM_TIMEOUT=4, CNT_W=4).
// Each step drives one cycle of inputs just after the rising edge and queues the
// hand-computed expected outputs; the monitor pops and compares on the falling edge.
module tb_hazard_control_unit;

  localparam int unsigned MemTimeout = 4;
  localparam int unsigned CntW       = 4;

  localparam logic [3:0] WeAll  = 4'b1111;  // {PC, IF_ID, ID_EX, EX_MEM}
  localparam logic [3:0] WeNone = 4'b0000;
  localparam logic [3:0] WeLu   = 4'b0011;
  localparam logic [3:0] FNone  = 4'b0000;  // {ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble}
  localparam logic [3:0] FLu    = 4'b1000;
  localparam logic [3:0] FBr    = 4'b0110;
  localparam logic [3:0] FFrz   = 4'b0001;

  typedef struct {
    logic       rst;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       br;
    logic       macc;
    logic       rdy;
  } in_t;

  typedef struct {
    string      name;
    logic [3:0] we;
    logic [3:0] fl;
    logic       err;
    int         stall;
    int         flush;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  hazard_control_unit_if #(.CNT_W(CntW)) hif ();

  hazard_control_unit #(
    .MEM_TIMEOUT(MemTimeout),
    .CNT_W      (CntW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hcu  (hif)
  );

  always #5 clk = ~clk;

  function automatic in_t mk(input logic rst, input logic mr, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                             input logic u2, input logic br, input logic macc,
                             input logic rdy);
    in_t v;
    v.rst = rst; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.u1 = u1; v.u2 = u2; v.br = br; v.macc = macc; v.rdy = rdy;
    return v;
  endfunction

  task automatic step(input in_t v, input logic [3:0] we, input logic [3:0] fl,
                      input logic err, input int st, input int fc, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset                 = v.rst;
    hif.ID_EX_MemRead     = v.mr;
    hif.ID_EX_RegisterRD  = v.rd;
    hif.IF_ID_RegisterRS1 = v.rs1;
    hif.IF_ID_RegisterRS2 = v.rs2;
    hif.IF_ID_UsesRS1     = v.u1;
    hif.IF_ID_UsesRS2     = v.u2;
    hif.BranchTaken       = v.br;
    hif.EX_MEM_MemAccess  = v.macc;
    hif.DMemReady         = v.rdy;
    e.name = nm; e.we = we; e.fl = fl; e.err = err; e.stall = st; e.flush = fc;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are stable by the falling edge.
  exp_t       m_e;
  logic [3:0] a_we, a_fl;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      m_e  = sb_q.pop_front();
      a_we = {hif.PCWrite, hif.IF_ID_Write, hif.ID_EX_Write, hif.EX_MEM_Write};
      a_fl = {hif.ID_EX_Bubble, hif.IF_ID_Flush, hif.ID_EX_Flush, hif.MEM_WB_Bubble};
      n_tests++;
      if (a_we !== m_e.we) begin
        n_fail++;
        $display("FAIL %s: enables got %b want %b", m_e.name, a_we, m_e.we);
      end
      if (a_fl !== m_e.fl) begin
        n_fail++;
        $display("FAIL %s: bubble/flush got %b want %b", m_e.name, a_fl, m_e.fl);
      end
      if (hif.MemTimeoutErr !== m_e.err || hif.StallCount !== CntW'(m_e.stall) ||
          hif.FlushCount !== CntW'(m_e.flush)) begin
        n_fail++;
        $display("FAIL %s: got err=%b stall=%0d flush=%0d, want err=%b stall=%0d flush=%0d",
                 m_e.name, hif.MemTimeoutErr, hif.StallCount, hif.FlushCount,
                 m_e.err, m_e.stall, m_e.flush);
      end
    end
  end

  initial begin
    in_t idle, rst_v, lu5, rd0, lu_rs2, nouse, br_lu, mw_br, rdy_br, mw, mw_rst;
    //          rst mr rd  rs1 rs2 u1 u2 br mac rdy
    idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_v  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu5    = mk(0, 1, 5, 5, 0, 1, 0, 0, 0, 0);
    rd0    = mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    lu_rs2 = mk(0, 1, 7, 3, 7, 0, 1, 0, 0, 0);
    nouse  = mk(0, 1, 7, 7, 7, 0, 0, 0, 0, 0);
    br_lu  = mk(0, 1, 5, 5, 0, 1, 0, 1, 0, 0);
    mw_br  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    rdy_br = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    mw     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    mw_rst = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Reset and load-use
    step(rst_v,  WeNone, FNone, 0, 0, 0, "reset");
    step(idle,   WeAll,  FNone, 0, 0, 0, "run_idle");
    step(lu5,    WeLu,   FLu,   0, 0, 0, "loaduse");
    step(idle,   WeAll,  FNone, 0, 1, 0, "lu_single_bubble");
    step(rd0,    WeAll,  FNone, 0, 1, 0, "rd0_no_stall");
    step(lu_rs2, WeLu,   FLu,   0, 1, 0, "loaduse_rs2");
    step(nouse,  WeAll,  FNone, 0, 2, 0, "unused_src_no_stall");
    // Branch beats load-use
    step(br_lu,  WeAll,  FBr,   0, 2, 0, "branch_over_lu");
    step(idle,   WeAll,  FNone, 0, 2, 1, "flush_counted");
    // Memory wait with a branch held; flush applied only on the ready cycle
    step(mw_br,  WeNone, FFrz,  0, 2, 1, "memwait_1");
    step(mw_br,  WeNone, FFrz,  0, 3, 1, "memwait_2");
    step(mw_br,  WeNone, FFrz,  0, 4, 1, "memwait_3");
    step(rdy_br, WeAll,  FBr,   0, 5, 1, "mem_ready_branch");
    step(idle,   WeAll,  FNone, 0, 5, 2, "back_in_run");
    // Timeout: four wait cycles then trap
    step(mw,     WeNone, FFrz,  0, 5, 2, "timeout_w1");
    step(mw,     WeNone, FFrz,  0, 6, 2, "timeout_w2");
    step(mw,     WeNone, FFrz,  0, 7, 2, "timeout_w3");
    step(mw,     WeNone, FFrz,  0, 8, 2, "timeout_w4");
    step(mw,     WeNone, FFrz,  1, 9, 2, "trap_entered");
    step(rdy_br, WeNone, FFrz,  1, 10, 2, "trap_ignores_ready");
    step(idle,   WeNone, FFrz,  1, 11, 2, "trap_holds");
    step(rst_v,  WeNone, FNone, 0, 0, 0, "trap_reset");
    step(idle,   WeAll,  FNone, 0, 0, 0, "run_after_trap");
    // Asynchronous reset in the middle of a wait
    step(mw,     WeNone, FFrz,  0, 0, 0, "rw_wait_1");
    step(mw,     WeNone, FFrz,  0, 1, 0, "rw_wait_2");
    step(mw_rst, WeNone, FNone, 0, 0, 0, "rw_async_reset");
    step(idle,   WeAll,  FNone, 0, 0, 0, "rw_run");
    // Stall counter saturation at 15
    for (int i = 0; i < 20; i++) begin
      step(lu5, WeLu, FLu, 0, (i > 15) ? 15 : i, 0, "sat_stall");
    end
    step(idle,   WeAll,  FNone, 0, 15, 0, "sat_value");
    step(lu5,    WeLu,   FLu,   0, 15, 0, "sat_more");
    step(idle,   WeAll,  FNone, 0, 15, 0, "sat_holds");

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
